// File: rtl/oser_gearbox_tx.sv
// -----------------------------------------------------------------------------
// oser_gearbox_tx
//
// Soft N:1 output serializer for the differential / LVDS output path.
// RATIO-bit words arrive on a valid/ready handshake. One serial bit per clk
// leaves on each channel. A word-rate clock (pclk_o) comes out of the same
// posedge-only logic.
//
// Handshake: a word transfers on a posedge where s_valid && s_ready.
// s_ready is the inverse of the hold-buffer "full" flag. While s_valid is low,
// s_data is ignored.
//
// Optional build macro:
//   OSER_PRBS_FILL_EN - when defined, underrun fill bits come from a PRBS7 LFSR
//                       (seed 7'h7F, bit = lfsr[6]) instead of all zeros.
//
// Parameters:
//   RATIO     bits per word per channel (2..16)
//   CHANNELS  serial lanes sharing one bit counter (1..8)
//   MSB_FIRST 0: bit 0 is sent first, 1: bit RATIO-1 is sent first
//
// Ports:
//   clk          in   serial bit clock, all logic on posedge
//   rst_i        in   asynchronous reset, active-low
//   enable       in   1 = run, 0 = finish the current word then idle
//   s_data       in   word, lane c uses bits [c*RATIO +: RATIO]
//   s_valid      in   s_data valid
//   s_ready      out  hold buffer can accept a word
//   q            out  serial outputs, registered
//   pclk_o       out  word-rate clock, registered
//   frame_o      out  high while bit index 0 of a word is on q
//   underrun_o   out  sticky, set when a fill word is inserted
//   underrun_clr in   clears underrun_o (a set on the same cycle wins)
//   state_o      out  debug view of the FSM state (0 idle, 1 prime, 2 run)
// -----------------------------------------------------------------------------
module oser_gearbox_tx #(
    parameter int RATIO     = 10,
    parameter int CHANNELS  = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic                        enable,
    input  logic [CHANNELS*RATIO-1:0]   s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [CHANNELS-1:0]         q,
    output logic                        pclk_o,
    output logic                        frame_o,
    output logic                        underrun_o,
    input  logic                        underrun_clr,
    output logic [1:0]                  state_o
);

    localparam int W    = CHANNELS * RATIO;
    localparam int CW   = $clog2(RATIO);
    localparam int HALF = (RATIO + 1) / 2;

    localparam logic [CW-1:0] LAST_C = CW'(RATIO - 1);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [W-1:0]        shift_q, shift_d;
    logic [CHANNELS-1:0] q_q, q_d;
    logic                pclk_q, pclk_d;
    logic                frame_q, frame_d;
    logic                underrun_q, underrun_d;

    logic                accept;
    logic                load_hold;
    logic                load_fill;
    logic                step;
    logic [W-1:0]        src_word;

`ifdef OSER_PRBS_FILL_EN
    logic [6:0]          lfsr_q, lfsr_d;
    // Marks that the word currently being shifted is a fill word, so its
    // bits are taken from the LFSR rather than from shift_q.
    logic                fill_q, fill_d;
`endif

    assign accept = s_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        q_d         = '0;
        underrun_d  = underrun_q;
        load_hold   = 1'b0;
        load_fill   = 1'b0;
        step        = 1'b0;
        src_word    = '0;
        pclk_d      = 1'b0;
        frame_d     = 1'b0;
`ifdef OSER_PRBS_FILL_EN
        lfsr_d      = lfsr_q;
        fill_d      = fill_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                cnt_d = '0;
                // enable low wins over a waiting word; the word stays held.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (hold_full_q) begin
                    load_hold = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (hold_full_q) begin
                        load_hold = 1'b1;
                    end else begin
                        load_fill = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    step  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load puts the first bit of the new word on q straight away and
        // keeps the remaining bits in shift_q. A fill word is all zeros here.
        if (load_hold) begin
            src_word = hold_q;
        end else if (step) begin
            src_word = shift_q;
        end

        if (load_hold || load_fill || step) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (MSB_FIRST != 0) begin
                    q_d[c]                     = src_word[c*RATIO + RATIO - 1];
                    shift_d[c*RATIO +: RATIO]  = {src_word[c*RATIO +: RATIO-1], 1'b0};
                end else begin
                    q_d[c]                     = src_word[c*RATIO];
                    shift_d[c*RATIO +: RATIO]  = {1'b0, src_word[c*RATIO + 1 +: RATIO-1]};
                end
            end
        end

`ifdef OSER_PRBS_FILL_EN
        if (load_hold || load_fill) begin
            fill_d = load_fill;
        end
        if (state_d != ST_RUN) begin
            fill_d = 1'b0;
        end
        // The LFSR only advances on cycles that actually emit a fill bit.
        if (load_fill || (step && fill_q)) begin
            q_d    = {CHANNELS{lfsr_q[6]}};
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
`endif

        // Accept and load-from-hold never coincide: accept needs an empty
        // hold, load needs a full one.
        if (load_hold) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end

        if (load_fill) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        // cnt_d is the index of the bit that will be on q after this edge.
        if (state_d == ST_RUN) begin
            pclk_d  = (cnt_d < HALF_C);
            frame_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            q_q         <= '0;
            pclk_q      <= 1'b0;
            frame_q     <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef OSER_PRBS_FILL_EN
            lfsr_q      <= 7'h7F;
            fill_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            q_q         <= q_d;
            pclk_q      <= pclk_d;
            frame_q     <= frame_d;
            underrun_q  <= underrun_d;
`ifdef OSER_PRBS_FILL_EN
            lfsr_q      <= lfsr_d;
            fill_q      <= fill_d;
`endif
        end
    end

    assign s_ready    = !hold_full_q;
    assign q          = q_q;
    assign pclk_o     = pclk_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;
    assign state_o    = state_q;

endmodule
